button_event_decoder: RTL

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/button_event_decoder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: button FSM encoding and default tick counts.
// Revision 1.0 - initial release.
`default_nettype none

package stopwatch_pkg;

  localparam int DEFAULT_LONG_TICKS   = 1000;
  localparam int DEFAULT_REPEAT_TICKS = 200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHORT = 2'd1,
    LONG  = 2'd2
  } btn_state_e;

endpackage

`default_nettype wire

// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced active-low button into press/short/long/repeat/release pulses.
// Optional macro BUTTON_AUTO_REPEAT_EN enables auto-repeat while a long hold continues. Revision 1.0.
`default_nettype none

module button_event_decoder
  import stopwatch_pkg::*;
#(
  parameter int LONG_TICKS   = DEFAULT_LONG_TICKS,
  parameter int REPEAT_TICKS = DEFAULT_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_en,
  input  logic btn_in,
  output logic press_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic release_pulse,
  output logic held
);

  localparam logic [15:0] LONG_LAST = 16'(LONG_TICKS - 1);

  btn_state_e  state, state_d;
  logic [15:0] hold_cnt, hold_d;
  logic        btn_prev;
  logic        press_d, short_d, long_d, rel_d;
  logic        press_edge, release_edge;

  assign press_edge   = btn_prev & ~btn_in;
  assign release_edge = ~btn_prev & btn_in;
  assign held         = (state != IDLE);

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [15:0] REPEAT_LAST = 16'(REPEAT_TICKS - 1);

  logic [15:0] rep_cnt, rep_d;
  logic        repeat_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      rep_cnt      <= rep_d;
      repeat_pulse <= repeat_d;
    end
  end
`else
  logic unused_repeat_ticks;
  assign unused_repeat_ticks = ^REPEAT_TICKS;
  assign repeat_pulse        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      btn_prev      <= 1'b1;
      press_pulse   <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_d;
      hold_cnt      <= hold_d;
      btn_prev      <= btn_in;
      press_pulse   <= press_d;
      short_press   <= short_d;
      long_press    <= long_d;
      release_pulse <= rel_d;
    end
  end

  always_comb begin
    state_d  = state;
    hold_d   = hold_cnt;
    press_d  = 1'b0;
    short_d  = 1'b0;
    long_d   = 1'b0;
    rel_d    = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
    rep_d    = rep_cnt;
    repeat_d = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (press_edge) begin
          state_d = SHORT;
          hold_d  = '0;
          press_d = 1'b1;
        end
      end
      SHORT: begin
        // A release always wins over a coincident tick.
        if (release_edge) begin
          short_d = 1'b1;
          rel_d   = 1'b1;
          state_d = IDLE;
        end else if (clk_en) begin
          if (hold_cnt == LONG_LAST) begin
            long_d  = 1'b1;
            state_d = LONG;
`ifdef BUTTON_AUTO_REPEAT_EN
            rep_d   = '0;
`endif
          end else if (hold_cnt != 16'hFFFF) begin
            hold_d = hold_cnt + 16'd1;
          end
        end
      end
      LONG: begin
        if (release_edge) begin
          rel_d   = 1'b1;
          state_d = IDLE;
        end
`ifdef BUTTON_AUTO_REPEAT_EN
        else if (clk_en) begin
          if (rep_cnt == REPEAT_LAST) begin
            repeat_d = 1'b1;
            rep_d    = '0;
          end else if (rep_cnt != 16'hFFFF) begin
            rep_d = rep_cnt + 16'd1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire
